// File: rtl/gmux_quad_ctrl.sv
// rtl/gmux_quad_ctrl.sv - GMUX source-select and per-quadrant enable sequencer
// Glitch-safe source switching and OFF-dwell low-power entry/exit, all outputs registered.
module gmux_quad_ctrl #(
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int VLP_CYCLES    = 2,
    parameter int CNT_W         = 8
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       SW_VALID,
    input  logic       SW_SEL,
    output logic       SW_READY,
    input  logic       REQ_VALID,
    input  logic [1:0] REQ_QUAD,
    input  logic [1:0] REQ_MODE,
    output logic       REQ_READY,
    input  logic [3:0] DYN_EN,
    output logic       DONE,
    output logic       BUSY,
    output logic       SSEL,
    output logic       TL_SEN,
    output logic       TR_SEN,
    output logic       BL_SEN,
    output logic       BR_SEN,
    output logic       TL_DEN,
    output logic       TR_DEN,
    output logic       BL_DEN,
    output logic       BR_DEN,
    output logic       TL_DYNEN,
    output logic       TR_DYNEN,
    output logic       BL_DYNEN,
    output logic       BR_DYNEN,
    output logic       TL_VLP,
    output logic       TR_VLP,
    output logic       BL_VLP,
    output logic       BR_VLP
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GATE     = 3'd1;
    localparam logic [2:0] ST_SWITCH   = 3'd2;
    localparam logic [2:0] ST_SETTLE   = 3'd3;
    localparam logic [2:0] ST_VLP_WAIT = 3'd4;

    localparam logic [1:0] M_ON     = 2'd0;
    localparam logic [1:0] M_DYN    = 2'd1;
    localparam logic [1:0] M_OFF    = 2'd2;
    localparam logic [1:0] M_LOWPWR = 2'd3;

    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] VLP_LAST    = CNT_W'(VLP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0][1:0]  mode, mode_n;
    logic             gated, gated_n;
    logic             sel_cap, sel_cap_n;
    logic             ssel_q, ssel_n;
    logic [1:0]       tgt_quad, tgt_quad_n;
    logic [1:0]       tgt_mode, tgt_mode_n;
    logic             done_n;

    logic [3:0] sen_q, den_q, dynen_q, vlp_q;
    logic [3:0] sen_n, den_n, dynen_n, vlp_n;
    logic       done_q, busy_q, ready_q;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        mode_n     = mode;
        gated_n    = gated;
        sel_cap_n  = sel_cap;
        ssel_n     = ssel_q;
        tgt_quad_n = tgt_quad;
        tgt_mode_n = tgt_mode;
        done_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                // A switch request always takes priority over a mode request.
                if (SW_VALID) begin
                    if (SW_SEL == ssel_q) begin
                        done_n = 1'b1;
                    end else begin
                        state_n   = ST_GATE;
                        gated_n   = 1'b1;
                        cnt_n     = '0;
                        sel_cap_n = SW_SEL;
                    end
                end else if (REQ_VALID) begin
                    if ((REQ_MODE == M_LOWPWR) != (mode[REQ_QUAD] == M_LOWPWR)) begin
                        mode_n[REQ_QUAD] = M_OFF;
                        tgt_quad_n       = REQ_QUAD;
                        tgt_mode_n       = REQ_MODE;
                        cnt_n            = '0;
                        state_n          = ST_VLP_WAIT;
                    end else begin
                        mode_n[REQ_QUAD] = REQ_MODE;
                        done_n           = 1'b1;
                    end
                end
            end
            ST_GATE: begin
                if (cnt == GATE_LAST) state_n = ST_SWITCH;
                else                  cnt_n   = cnt + CNT_ONE;
            end
            ST_SWITCH: begin
                ssel_n  = sel_cap;
                cnt_n   = '0;
                state_n = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    gated_n = 1'b0;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ST_VLP_WAIT: begin
                if (cnt == VLP_LAST) begin
                    mode_n[tgt_quad] = tgt_mode;
                    done_n           = 1'b1;
                    state_n          = ST_IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output decode is computed from next-state values so every pin comes straight off a flop.
    always_comb begin
        sen_n   = '0;
        den_n   = '0;
        dynen_n = '0;
        vlp_n   = '0;
        for (int q = 0; q < 4; q++) begin
            sen_n[q]   = (mode_n[q] == M_ON) && !gated_n;
            den_n[q]   = (mode_n[q] == M_DYN) || (gated_n && (mode_n[q] == M_ON));
            dynen_n[q] = (mode_n[q] == M_DYN) && !gated_n && DYN_EN[q];
            vlp_n[q]   = (mode_n[q] == M_LOWPWR);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mode     <= {4{M_ON}};
            gated    <= 1'b0;
            sel_cap  <= 1'b0;
            ssel_q   <= 1'b0;
            tgt_quad <= 2'd0;
            tgt_mode <= M_ON;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            sen_q    <= 4'hF;
            den_q    <= 4'h0;
            dynen_q  <= 4'h0;
            vlp_q    <= 4'h0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            mode     <= mode_n;
            gated    <= gated_n;
            sel_cap  <= sel_cap_n;
            ssel_q   <= ssel_n;
            tgt_quad <= tgt_quad_n;
            tgt_mode <= tgt_mode_n;
            done_q   <= done_n;
            busy_q   <= (state_n != ST_IDLE);
            ready_q  <= (state_n == ST_IDLE);
            sen_q    <= sen_n;
            den_q    <= den_n;
            dynen_q  <= dynen_n;
            vlp_q    <= vlp_n;
        end
    end

    assign SW_READY  = ready_q;
    assign REQ_READY = ready_q;
    assign DONE      = done_q;
    assign BUSY      = busy_q;
    assign SSEL      = ssel_q;

    assign TL_SEN   = sen_q[0];
    assign TR_SEN   = sen_q[1];
    assign BL_SEN   = sen_q[2];
    assign BR_SEN   = sen_q[3];
    assign TL_DEN   = den_q[0];
    assign TR_DEN   = den_q[1];
    assign BL_DEN   = den_q[2];
    assign BR_DEN   = den_q[3];
    assign TL_DYNEN = dynen_q[0];
    assign TR_DYNEN = dynen_q[1];
    assign BL_DYNEN = dynen_q[2];
    assign BR_DYNEN = dynen_q[3];
    assign TL_VLP   = vlp_q[0];
    assign TR_VLP   = vlp_q[1];
    assign BL_VLP   = vlp_q[2];
    assign BR_VLP   = vlp_q[3];

endmodule

// File: tb/tb_gmux_quad_ctrl.sv
// tb/tb_gmux_quad_ctrl.sv - directed self-checking bench for gmux_quad_ctrl
module tb_gmux_quad_ctrl;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       SW_VALID, SW_SEL, REQ_VALID;
    logic [1:0] REQ_QUAD, REQ_MODE;
    logic [3:0] DYN_EN;
    logic       SW_READY, REQ_READY, DONE, BUSY, SSEL;
    logic       TL_SEN, TR_SEN, BL_SEN, BR_SEN;
    logic       TL_DEN, TR_DEN, BL_DEN, BR_DEN;
    logic       TL_DYNEN, TR_DYNEN, BL_DYNEN, BR_DYNEN;
    logic       TL_VLP, TR_VLP, BL_VLP, BR_VLP;

    logic [3:0] sen, den, dynen, vlp;
    assign sen   = {BR_SEN, BL_SEN, TR_SEN, TL_SEN};
    assign den   = {BR_DEN, BL_DEN, TR_DEN, TL_DEN};
    assign dynen = {BR_DYNEN, BL_DYNEN, TR_DYNEN, TL_DYNEN};
    assign vlp   = {BR_VLP, BL_VLP, TR_VLP, TL_VLP};

    int checks = 0;
    int errors = 0;
    int done_seen;

    always #5 CLK = ~CLK;

    gmux_quad_ctrl dut (
        .CLK(CLK), .RESETN(RESETN),
        .SW_VALID(SW_VALID), .SW_SEL(SW_SEL), .SW_READY(SW_READY),
        .REQ_VALID(REQ_VALID), .REQ_QUAD(REQ_QUAD), .REQ_MODE(REQ_MODE), .REQ_READY(REQ_READY),
        .DYN_EN(DYN_EN), .DONE(DONE), .BUSY(BUSY), .SSEL(SSEL),
        .TL_SEN(TL_SEN), .TR_SEN(TR_SEN), .BL_SEN(BL_SEN), .BR_SEN(BR_SEN),
        .TL_DEN(TL_DEN), .TR_DEN(TR_DEN), .BL_DEN(BL_DEN), .BR_DEN(BR_DEN),
        .TL_DYNEN(TL_DYNEN), .TR_DYNEN(TR_DYNEN), .BL_DYNEN(BL_DYNEN), .BR_DYNEN(BR_DYNEN),
        .TL_VLP(TL_VLP), .TR_VLP(TR_VLP), .BL_VLP(BL_VLP), .BR_VLP(BR_VLP)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_quads(input string tag, input logic [3:0] e_sen, input logic [3:0] e_den,
                             input logic [3:0] e_dyn, input logic [3:0] e_vlp);
        chk({tag, "_sen"}, {4'h0, sen}, {4'h0, e_sen});
        chk({tag, "_den"}, {4'h0, den}, {4'h0, e_den});
        chk({tag, "_dynen"}, {4'h0, dynen}, {4'h0, e_dyn});
        chk({tag, "_vlp"}, {4'h0, vlp}, {4'h0, e_vlp});
    endtask

    initial begin
        RESETN = 1'b0; SW_VALID = 1'b0; SW_SEL = 1'b0;
        REQ_VALID = 1'b0; REQ_QUAD = 2'd0; REQ_MODE = 2'd0; DYN_EN = 4'h0;
        step(); step();
        RESETN = 1'b1;
        step();

        // 1: reset / idle state
        chk_quads("rst", 4'hF, 4'h0, 4'h0, 4'h0);
        chk("rst_ssel", {7'd0, SSEL}, 8'd0);
        chk("rst_ready", {6'd0, SW_READY, REQ_READY}, 8'd3);
        chk("rst_busy_done", {6'd0, BUSY, DONE}, 8'd0);

        // 2: switch to GHSCK, 14-cycle sequence
        SW_VALID = 1'b1; SW_SEL = 1'b1;
        step();
        SW_VALID = 1'b0;
        chk("sw1_ready", {6'd0, SW_READY, REQ_READY}, 8'd0);
        for (int k = 1; k <= 14; k++) begin
            chk("sw1_sen", {4'h0, sen}, (k == 14) ? 8'h0F : 8'h00);
            chk("sw1_den", {4'h0, den}, (k == 14) ? 8'h00 : 8'h0F);
            chk("sw1_ssel", {7'd0, SSEL}, (k >= 6) ? 8'd1 : 8'd0);
            chk("sw1_done", {7'd0, DONE}, (k == 14) ? 8'd1 : 8'd0);
            chk("sw1_busy", {7'd0, BUSY}, (k == 14) ? 8'd0 : 8'd1);
            if (k < 14) step();
        end
        step();
        chk("sw1_done_pulse", {7'd0, DONE}, 8'd0);

        // 3: BL into LOWPWR and back to ON
        REQ_VALID = 1'b1; REQ_QUAD = 2'd2; REQ_MODE = 2'd3;
        step();
        REQ_VALID = 1'b0;
        chk_quads("lp_in1", 4'b1011, 4'h0, 4'h0, 4'h0);
        chk("lp_in1_rdy_done", {6'd0, REQ_READY, DONE}, 8'd0);
        step();
        chk_quads("lp_in2", 4'b1011, 4'h0, 4'h0, 4'h0);
        step();
        chk_quads("lp_in3", 4'b1011, 4'h0, 4'h0, 4'b0100);
        chk("lp_in3_done_busy", {6'd0, DONE, BUSY}, 8'd2);
        REQ_VALID = 1'b1; REQ_QUAD = 2'd2; REQ_MODE = 2'd0;
        step();
        REQ_VALID = 1'b0;
        chk_quads("lp_out1", 4'b1011, 4'h0, 4'h0, 4'h0);
        step();
        chk_quads("lp_out2", 4'b1011, 4'h0, 4'h0, 4'h0);
        chk("lp_out2_done", {7'd0, DONE}, 8'd0);
        step();
        chk_quads("lp_out3", 4'hF, 4'h0, 4'h0, 4'h0);
        chk("lp_out3_done", {7'd0, DONE}, 8'd1);

        // 4: simultaneous switch and mode request; switch wins, request stays pending
        SW_VALID = 1'b1; SW_SEL = 1'b0;
        REQ_VALID = 1'b1; REQ_QUAD = 2'd0; REQ_MODE = 2'd2;
        step();
        SW_VALID = 1'b0;
        chk_quads("both1", 4'h0, 4'hF, 4'h0, 4'h0);
        chk("both1_req_ready", {7'd0, REQ_READY}, 8'd0);
        repeat (13) step();
        chk_quads("both14", 4'hF, 4'h0, 4'h0, 4'h0);
        chk("both14_ssel_done", {6'd0, SSEL, DONE}, 8'd1);
        chk("both14_req_ready", {7'd0, REQ_READY}, 8'd1);
        step();
        REQ_VALID = 1'b0;
        chk_quads("both15", 4'b1110, 4'h0, 4'h0, 4'h0);
        chk("both15_done", {7'd0, DONE}, 8'd1);
        REQ_VALID = 1'b1; REQ_MODE = 2'd0;
        step();
        REQ_VALID = 1'b0;
        chk("tl_on_sen", {4'h0, sen}, 8'h0F);

        // 5: TR dynamic mode, DYNEN tracks DYN_EN with one cycle delay, held 0 while gated
        REQ_VALID = 1'b1; REQ_QUAD = 2'd1; REQ_MODE = 2'd1;
        step();
        REQ_VALID = 1'b0;
        chk_quads("dyn1", 4'b1101, 4'b0010, 4'h0, 4'h0);
        chk("dyn1_done", {7'd0, DONE}, 8'd1);
        DYN_EN = 4'b0010;
        step();
        chk("dyn2_dynen", {4'h0, dynen}, 8'h02);
        DYN_EN = 4'b0000;
        step();
        chk("dyn3_dynen", {4'h0, dynen}, 8'h00);
        DYN_EN = 4'b0010;
        step();
        chk("dyn4_dynen", {4'h0, dynen}, 8'h02);
        SW_VALID = 1'b1; SW_SEL = 1'b1;
        step();
        SW_VALID = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k < 14) chk_quads("dynsw_gated", 4'h0, 4'hF, 4'h0, 4'h0);
            else        chk_quads("dynsw_end", 4'b1101, 4'b0010, 4'b0010, 4'h0);
            if (k < 14) step();
        end
        chk("dynsw_ssel_done", {6'd0, SSEL, DONE}, 8'd3);

        // 6: switch back to GCLKIN, then reset in the middle of a new switch's SETTLE
        SW_VALID = 1'b1; SW_SEL = 1'b0;
        step();
        SW_VALID = 1'b0;
        repeat (13) step();
        chk("back_ssel_done", {6'd0, SSEL, DONE}, 8'd1);
        SW_VALID = 1'b1; SW_SEL = 1'b1;
        step();
        SW_VALID = 1'b0;
        repeat (7) step();
        chk("rst6_pre_ssel_busy", {6'd0, SSEL, BUSY}, 8'd3);
        chk_quads("rst6_pre", 4'h0, 4'hF, 4'h0, 4'h0);
        RESETN = 1'b0;
        #1;
        chk_quads("rst6", 4'hF, 4'h0, 4'h0, 4'h0);
        chk("rst6_ssel_busy_done", {5'd0, SSEL, BUSY, DONE}, 8'd0);
        chk("rst6_ready", {6'd0, SW_READY, REQ_READY}, 8'd3);
        step(); step();
        RESETN = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (DONE) done_seen++;
        end
        chk("rst6_no_done", 8'(done_seen), 8'd0);
        chk("rst6_after_ssel_busy", {6'd0, SSEL, BUSY}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
